// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding, default sizes and error-counter width for the configuration sequencer
package fpga_cfg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, RELEASE, DONE} state_t;
  localparam int CCFF_LEN_DEF = 1024;
  localparam int SC_LEN_DEF = 1024;
  localparam int WORD_W_DEF = 32;
  localparam int ERR_W = 16;
endpackage

// File: rtl/cfg_piso.sv
// cfg_piso: word-wide parallel-in serial-out feeder for the configuration chain, MSB first, with chain bit counter
module cfg_piso import fpga_cfg_pkg::*; #(
  parameter int CCFF_LEN = CCFF_LEN_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              clear,
  input  logic              en,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  output logic              chain_full
);
  localparam int CW = $clog2(CCFF_LEN + 1);
  localparam int NW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LEN_C = CW'(CCFF_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(CCFF_LEN - 1);
  localparam logic [NW-1:0] FULL_C = NW'(WORD_W);
  logic [WORD_W-1:0] sreg;
  logic [NW-1:0] nbits;
  logic [CW-1:0] bit_cnt;
  logic last_bit, empty, shift;
  always_comb begin
    empty = nbits == '0;
    shift = en && !empty;
    word_ready = en && empty && bit_cnt < LEN_C;
    prog_clk_en = shift;
    ccff_head = empty ? last_bit : sreg[WORD_W-1];
    chain_full = shift && bit_cnt == LAST_C;
  end
  always_ff @(posedge prog_clk)
    if (prog_reset || clear) begin
      sreg <= '0;
      nbits <= '0;
      bit_cnt <= '0;
      last_bit <= 1'b0;
    end else if (word_valid && word_ready) begin
      sreg <= word_data;
      nbits <= FULL_C;
    end else if (shift) begin
      sreg <= sreg << 1;
      last_bit <= sreg[WORD_W-1];
      bit_cnt <= bit_cnt + CW'(1);
      nbits <= chain_full ? '0 : nbits - NW'(1);
    end
endmodule

// File: rtl/fpga_cfg_sequencer.sv
// fpga_cfg_sequencer: loads the configuration chain, checks the scan chain with a walking one, then releases the fabric
module fpga_cfg_sequencer import fpga_cfg_pkg::*; #(
  parameter int CCFF_LEN = CCFF_LEN_DEF,
  parameter int SC_LEN = SC_LEN_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  output logic              sc_head,
  input  logic              sc_tail,
  output logic              sc_en,
  output logic              fabric_reset,
  output logic              io_isol_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ERR_W-1:0]  err_count
);
  localparam int SW = $clog2(SC_LEN + 4);
  localparam logic [SW-1:0] CHK0 = SW'(SC_LEN + 1);
  localparam logic [SW-1:0] CHK1 = SW'(SC_LEN + 2);
  localparam logic [SW-1:0] CHK2 = SW'(SC_LEN + 3);
  state_t state;
  logic [SW-1:0] scan_cnt;
  logic tail_q, chk, mism, clear, chain_full;
  always_comb begin
    clear = start && (state == IDLE || state == DONE);
    chk = state == SCAN && (scan_cnt == CHK0 || scan_cnt == CHK1 || scan_cnt == CHK2);
    mism = chk && (tail_q !== (scan_cnt == CHK0));
  end
  always_ff @(posedge prog_clk)
    tail_q <= prog_reset ? 1'b0 : sc_tail;
  cfg_piso #(.CCFF_LEN(CCFF_LEN), .WORD_W(WORD_W)) u_piso (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .clear       (clear),
    .en          (state == LOAD),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .ccff_head   (ccff_head),
    .prog_clk_en (prog_clk_en),
    .chain_full  (chain_full)
  );
  always_ff @(posedge prog_clk)
    if (prog_reset) begin
      state <= IDLE;
      scan_cnt <= '0;
      err_count <= '0;
      sc_head <= 1'b0;
      sc_en <= 1'b0;
      fabric_reset <= 1'b1;
      io_isol_n <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= LOAD;
            scan_cnt <= '0;
            err_count <= '0;
            fabric_reset <= 1'b1;
            io_isol_n <= 1'b0;
            busy <= 1'b1;
            done <= 1'b0;
            error <= 1'b0;
          end
        LOAD:
          if (chain_full) begin
            state <= SCAN;
            sc_en <= 1'b1;
            sc_head <= 1'b1;
          end
        SCAN: begin
          scan_cnt <= scan_cnt + SW'(1);
          sc_head <= 1'b0;
          if (mism && err_count != '1) err_count <= err_count + ERR_W'(1);
          if (scan_cnt == CHK2) begin
            state <= RELEASE;
            sc_en <= 1'b0;
            fabric_reset <= 1'b0;
          end
        end
        RELEASE: begin
          state <= DONE;
          io_isol_n <= 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
          error <= err_count != '0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fpga_cfg_sequencer.sv
// tb_fpga_cfg_sequencer: directed checks of chain loading, starvation, scan check, release order, reset and restart
module tb_fpga_cfg_sequencer;
  logic prog_clk = 1'b0;
  logic prog_reset = 1'b1;
  logic start = 1'b0;
  logic word_valid = 1'b0;
  logic [31:0] word_data;
  logic word_ready, ccff_head, prog_clk_en, sc_head, sc_tail, sc_en;
  logic fabric_reset, io_isol_n, busy, done, error;
  logic [15:0] err_count;
  int passed = 0;
  int total = 0;
  int en_cnt = 0;
  int hs_cnt = 0;
  int sc_cnt = 0;
  int en_base = 0;
  int hs_base = 0;
  int sc_base = 0;
  int mode = 0;
  int fr, io;
  logic [39:0] stream = '0;
  logic [7:0] chain = '0;
  localparam logic [39:0] EXP_STREAM = 40'hA5A50F0FFF;

  always #5 prog_clk = ~prog_clk;

  assign word_data = (hs_cnt == hs_base) ? 32'hA5A50F0F : 32'hFF123456;
  assign sc_tail = mode == 0 ? chain[7] : mode == 1 ? 1'b0 : 1'b1;

  fpga_cfg_sequencer #(.CCFF_LEN(40), .SC_LEN(8), .WORD_W(32)) dut (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (start),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .ccff_head    (ccff_head),
    .prog_clk_en  (prog_clk_en),
    .sc_head      (sc_head),
    .sc_tail      (sc_tail),
    .sc_en        (sc_en),
    .fabric_reset (fabric_reset),
    .io_isol_n    (io_isol_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_count    (err_count)
  );

  always @(posedge prog_clk) begin
    if (prog_clk_en) begin
      stream <= {stream[38:0], ccff_head};
      en_cnt <= en_cnt + 1;
    end
    if (word_valid && word_ready) hs_cnt <= hs_cnt + 1;
    if (sc_en) begin
      sc_cnt <= sc_cnt + 1;
      chain <= {chain[6:0], sc_head};
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic start_run();
    hs_base = hs_cnt;
    en_base = en_cnt;
    sc_base = sc_cnt;
    word_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 200 && en_cnt - en_base < n; i++) @(negedge prog_clk);
    chk("bits_reached", 40'(en_cnt - en_base), 40'(n));
  endtask

  task automatic wait_scan();
    for (int i = 0; i < 300 && !sc_en; i++) @(negedge prog_clk);
    chk("scan_entry", 40'(sc_en), 40'd1);
    chk("scan_sc_head_first", 40'(sc_head), 40'd1);
    chk("scan_no_prog_clk", 40'(prog_clk_en), 40'd0);
    chk("load_stream", stream, EXP_STREAM);
    chk("load_bit_count", 40'(en_cnt - en_base), 40'd40);
    chk("load_handshakes", 40'(hs_cnt - hs_base), 40'd2);
    chk("ready_after_load", 40'(word_ready), 40'd0);
  endtask

  task automatic wait_done();
    fr = -1;
    io = -1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge prog_clk);
      if (fr < 0 && !fabric_reset) fr = i;
      if (io < 0 && io_isol_n) io = i;
    end
    chk("done_reached", 40'(done), 40'd1);
    chk("release_order", 40'(io - fr), 40'd1);
    chk("scan_cycles", 40'(sc_cnt - sc_base), 40'd12);
    chk("done_busy", 40'(busy), 40'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {word_ready, ccff_head, prog_clk_en, sc_head, sc_en, fabric_reset, io_isol_n,
              busy, done, error, 14'd0, err_count}, {10'b0000010000, 30'd0});
  endtask

  initial begin
    tick();
    tick();
    @(negedge prog_clk);
    chk_reset_outputs("reset_values");
    prog_reset = 1'b0;
    tick();
    start_run();
    @(negedge prog_clk);
    chk("load_busy", 40'(busy), 40'd1);
    chk("load_fabric_reset", 40'(fabric_reset), 40'd1);
    chk("load_ready_first", 40'(word_ready), 40'd1);
    wait_scan();
    wait_done();
    chk("good_err_count", 40'(err_count), 40'd0);
    chk("good_error", 40'(error), 40'd0);
    chk("good_io_isol_n", 40'(io_isol_n), 40'd1);
    mode = 1;
    start_run();
    @(negedge prog_clk);
    chk("restart_done_cleared", 40'(done), 40'd0);
    chk("restart_fabric_reset", {fabric_reset, io_isol_n}, 40'b10);
    wait_bits(32);
    word_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge prog_clk);
      chk("starve_no_prog_clk", 40'(prog_clk_en), 40'd0);
      chk("starve_head_hold", 40'(ccff_head), 40'd1);
    end
    tick();
    word_valid = 1'b1;
    wait_scan();
    repeat (3) @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    chk("scan_start_ignored", {sc_en, busy, done}, 40'b110);
    wait_done();
    chk("stuck0_err_count", 40'(err_count), 40'd1);
    chk("stuck0_error", 40'(error), 40'd1);
    mode = 2;
    start_run();
    @(negedge prog_clk);
    chk("restart_err_cleared", {error, err_count}, 40'd0);
    wait_scan();
    wait_done();
    chk("stuck1_err_count", 40'(err_count), 40'd2);
    chk("stuck1_error", 40'(error), 40'd1);
    mode = 0;
    start_run();
    wait_bits(17);
    prog_reset = 1'b1;
    start = 1'b1;
    tick();
    prog_reset = 1'b0;
    start = 1'b0;
    @(negedge prog_clk);
    chk_reset_outputs("midload_reset_values");
    start_run();
    wait_scan();
    wait_done();
    chk("reload_err_count", {error, err_count}, 40'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fpga_cfg_sequencer.md
FPGA_CFG_SEQUENCER -- requirements
Module: fpga_cfg_sequencer

Interface
REQ-001 Parameter CCFF_LEN, default 1024: configuration-chain length in bits, minimum 1.
REQ-002 Parameter SC_LEN, default 1024: scan-chain length in flops, minimum 1.
REQ-003 Parameter WORD_W, default 32: bitstream word width.
REQ-004 One clock and one reset; reset is synchronous and active-high.
REQ-005 prog_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 prog_reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle request to begin a program/scan/release sequence.
REQ-008 word_valid  in  1  bitstream word available.
REQ-009 word_data  in  WORD_W  bitstream word; MSB is shifted first.
REQ-010 word_ready  out  1  sequencer accepts word_data this cycle.
REQ-011 ccff_head  out  1  serial data into the configuration chain.
REQ-012 prog_clk_en  out  1  enable for the external fabric programming-clock gate; high only in cycles that shift the chain.
REQ-013 sc_head  out  1  serial data into the scan chain.
REQ-014 sc_tail  in  1  scan-chain output.
REQ-015 sc_en  out  1  fabric Test_en.
REQ-016 fabric_reset  out  1  fabric operating reset; active high.
REQ-017 io_isol_n  out  1  fabric IO isolation release; active low.
REQ-018 busy  out  1  high in LOAD, SCAN and RELEASE.
REQ-019 done  out  1  high in DONE.
REQ-020 error  out  1  high in DONE when err_count is nonzero.
REQ-021 err_count  out  16  saturating count of scan-check mismatches.

Function
REQ-022 States are IDLE, LOAD, SCAN, RELEASE and DONE.
REQ-023 In IDLE or DONE, start=1 moves to LOAD on the next edge and clears bit_cnt, scan_cnt and err_count; start is ignored while busy.
REQ-024 LOAD: word_ready=1 only when the shift register is empty and bit_cnt<CCFF_LEN; a handshake is word_valid and word_ready both high in the same cycle.
REQ-025 LOAD shift cycle: when the shift register holds a bit, ccff_head=that bit, prog_clk_en=1, bit_cnt increments, and the register shifts left.
REQ-026 A word accepted in cycle N presents its MSB on ccff_head in cycle N+1; with word_valid held high, the chain receives one bit every cycle except the single accept cycle per word.
REQ-027 Starvation: when the shift register is empty and word_valid=0, prog_clk_en=0 and ccff_head holds its last value; there is no timeout.
REQ-028 When bit_cnt reaches CCFF_LEN, move to SCAN; unshifted bits of the last word are discarded, and word_ready stays 0 after the last needed word.
REQ-029 SCAN: sc_en=1 and prog_clk_en=0; sc_head=1 only when scan_cnt=0, else 0; scan_cnt increments every cycle.
REQ-030 SCAN check: sampled sc_tail must be 1 at scan_cnt=SC_LEN+1 and 0 at SC_LEN+2 and SC_LEN+3.
REQ-031 Each SCAN check mismatch, including X/Z, increments err_count; err_count saturates at 16'hFFFF.
REQ-032 After the check at scan_cnt=SC_LEN+3, move to RELEASE.
REQ-033 RELEASE lasts exactly 1 cycle: fabric_reset=0, io_isol_n=0, sc_en=0; then move to DONE.
REQ-034 DONE: fabric_reset=0, io_isol_n=1, done=1, error=(err_count!=0); DONE is held until start or reset.
REQ-035 A restart from DONE reasserts fabric_reset=1 and io_isol_n=0 from the first LOAD cycle.
REQ-036 fabric_reset=1 in IDLE, LOAD and SCAN.

Reset
REQ-037 prog_reset=1 in any state forces IDLE on the next edge and discards the shift register and counters.
REQ-038 Reset values: word_ready=0, ccff_head=0, prog_clk_en=0, sc_head=0, sc_en=0, fabric_reset=1, io_isol_n=0, busy=0, done=0, error=0, err_count=0.
REQ-039 prog_reset has priority over start in the same cycle.

Structure
REQ-040 Shared package fpga_cfg_pkg holds the state enum, the default CCFF_LEN/SC_LEN/WORD_W constants, and the err_count width.
REQ-041 Sub-module cfg_piso (WORD_W parallel-in serial-out with empty flag and bit counter) implements REQ-024 to REQ-027; the FSM and the scan checker stay in the top.

Verification
REQ-042 CCFF_LEN=40, WORD_W=32, words 32'hA5A5_0F0F and 32'hFFxx_xxxx with valid always high -> ccff_head stream A5A50F0F then FF (40 bits); exactly 40 prog_clk_en cycles; word_ready low after 2 handshakes.
REQ-043 Same words, word_valid withheld for 5 cycles after bit 32 -> 5 cycles with prog_clk_en=0 and ccff_head stable; total prog_clk_en count is still 40.
REQ-044 SC_LEN=8, bench model of an 8-flop chain on sc_head -> sc_tail -> done=1, error=0, err_count=0; fabric_reset falls one cycle before io_isol_n rises.
REQ-045 SC_LEN=8, sc_tail stuck at 0 -> err_count=1, error=1; sc_tail stuck at 1 -> err_count=2.
REQ-046 prog_reset pulsed mid-LOAD at bit 17 -> next cycle all outputs equal REQ-038 values; a following start reloads from bit 0.
REQ-047 start pulsed during SCAN -> ignored, with no change in state or counters; start in DONE -> fresh sequence with err_count cleared.
